// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 access
// encodings, FSM state type and byte-lane / legality helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] lane_enable(input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << addr_lo;
      F3_H, F3_HU: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  // Loads accept all five encodings; stores only the signed-size ones.
  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfwords need an even address, words a word-aligned address.
  function automatic logic misaligned(input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_H, F3_HU: bad = addr_lo[0];
      F3_W:        bad = (addr_lo != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled single-port synchronous RAM, DEPTH_WORDS x 32 bits.
// Read is read-first: rdata shows the word as it was before any write
// on the same edge. Contents are not touched by any reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];
  logic [31:0] rdata_r;

  // Per-lane write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_r <= mem_r[addr];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder. Accepts one request at a time, waits a
// fixed LATENCY, performs the load/store on the final edge and holds the
// response until the consumer takes it. The RAM is read continuously from
// the request (in IDLE) or captured address (afterwards), so the read word
// is already valid when the access edge arrives, even for LATENCY=1.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t                state_r;
  logic [3:0]            cnt_r;
  logic                  we_r;
  logic [2:0]            funct3_r;
  logic [DATA_WIDTH-1:0] addr_r;
  logic [31:0]           wdata_r;
  logic                  req_ready_r;
  logic                  rsp_valid_r;
  logic                  rsp_err_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;

  logic                  access_s;
  logic                  err_s;
  logic [AW-1:0]         ram_addr_s;
  logic [3:0]            ram_we_s;
  logic [31:0]           ram_wdata_s;
  logic [31:0]           ram_rdata_s;
  logic [7:0]            byte_s;
  logic [15:0]           half_s;
  logic [31:0]           load_s;

  assign access_s = (state_r == WAIT) && (cnt_r == 4'd0);

  // Classify the captured request; out-of-range indices never wrap.
  always_comb begin
    err_s = 1'b0;
    if (!funct3_legal(we_r, funct3_r)) begin
      err_s = 1'b1;
    end else if (misaligned(funct3_r, addr_r[1:0])) begin
      err_s = 1'b1;
    end else if ({2'b00, addr_r[DATA_WIDTH-1:2]} >= DATA_WIDTH'(DEPTH_WORDS)) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // RAM port control: address source, lane enables and replicated store data.
  always_comb begin
    ram_addr_s  = (state_r == IDLE) ? req_addr[AW+1:2] : addr_r[AW+1:2];
    ram_we_s    = 4'b0000;
    ram_wdata_s = wdata_r;
    if (access_s && we_r && !err_s && !rst) begin
      ram_we_s = lane_enable(funct3_r, addr_r[1:0]);
    end else begin
      ram_we_s = 4'b0000;
    end
    case (funct3_r)
      F3_B:    ram_wdata_s = {4{wdata_r[7:0]}};
      F3_H:    ram_wdata_s = {2{wdata_r[15:0]}};
      default: ram_wdata_s = wdata_r;
    endcase
  end

  // Lane select and sign/zero extension of the loaded word.
  always_comb begin
    case (addr_r[1:0])
      2'd0:    byte_s = ram_rdata_s[7:0];
      2'd1:    byte_s = ram_rdata_s[15:8];
      2'd2:    byte_s = ram_rdata_s[23:16];
      2'd3:    byte_s = ram_rdata_s[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = addr_r[1] ? ram_rdata_s[31:16] : ram_rdata_s[15:0];
    case (funct3_r)
      F3_B:    load_s = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_s = {24'h000000, byte_s};
      F3_H:    load_s = {{16{half_s[15]}}, half_s};
      F3_HU:   load_s = {16'h0000, half_s};
      F3_W:    load_s = ram_rdata_s;
      default: load_s = 32'h0000_0000;
    endcase
  end

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            we_r        <= req_we;
            funct3_r    <= req_funct3;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata[31:0];
            cnt_r       <= CNT_LOAD;
            req_ready_r <= 1'b0;
            state_r     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= err_s;
            rsp_rdata_r <= (err_s || we_r) ? '0 : DATA_WIDTH'(load_s);
            state_r     <= RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
          cnt_r       <= 4'd0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .addr  (ram_addr_s),
    .we    (ram_we_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2, 256 words).
module tb_dmem_responder;

  localparam int DATA_WIDTH  = 32;
  localparam int DEPTH_WORDS = 256;
  localparam int LATENCY     = 2;

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .LATENCY     (LATENCY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  // One complete transaction with rsp_ready=1; called and returns 1ns after a rising edge.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int lat);
    int guard;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    checks++;
    if (guard >= 20) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, need 1", req_ready, guard);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: valid=%b err=%b, need 0/0", rsp_valid, rsp_err);
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h, need 00000000", rsp_rdata);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b, need 1", req_ready);
    end
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, W, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL sw_10: rdata=%h err=%b lat=%0d, need 0/0/2", rd, er, lat);
    end
    xact(1'b0, W, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL lw_10: rdata=%h err=%b lat=%0d, need deadbeef/0/2", rd, er, lat);
    end
  endtask

  task automatic test_subword;
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, B, 32'h13, 32'hFFFF_FF80, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL sb_13: rdata=%h err=%b, need 0/0", rd, er);
    end
    xact(1'b0, B, 32'h13, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
      errors++; $display("FAIL lb_13: rdata=%h err=%b, need ffffff80/0", rd, er);
    end
    xact(1'b0, BU, 32'h13, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00000080) begin
      errors++; $display("FAIL lbu_13: rdata=%h, need 00000080", rd);
    end
    xact(1'b0, W, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h80ADBEEF) begin
      errors++; $display("FAIL lw_10_after_sb: rdata=%h, need 80adbeef", rd);
    end
    xact(1'b0, H, 32'h12, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF80AD || er !== 1'b0) begin
      errors++; $display("FAIL lh_12: rdata=%h err=%b, need ffff80ad/0", rd, er);
    end
    xact(1'b0, HU, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0000BEEF) begin
      errors++; $display("FAIL lhu_10: rdata=%h, need 0000beef", rd);
    end
    xact(1'b0, B, 32'h11, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFFFFBE) begin
      errors++; $display("FAIL lb_11: rdata=%h, need ffffffbe", rd);
    end
    xact(1'b1, W, 32'h40, 32'h0, rd, er, lat);
    xact(1'b1, H, 32'h42, 32'h7777CAFE, rd, er, lat);
    xact(1'b1, B, 32'h41, 32'h1234565A, rd, er, lat);
    xact(1'b0, W, 32'h40, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hCAFE5A00) begin
      errors++; $display("FAIL lanes_40: rdata=%h, need cafe5a00", rd);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat;
    xact(1'b0, H, 32'h11, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
      errors++; $display("FAIL lh_11_misaligned: err=%b rdata=%h lat=%0d, need 1/0/2", er, rd, lat);
    end
    xact(1'b1, W, 32'h12, 32'h11111111, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
      errors++; $display("FAIL sw_12_misaligned: err=%b rdata=%h lat=%0d, need 1/0/2", er, rd, lat);
    end
    xact(1'b0, W, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h80ADBEEF || er !== 1'b0) begin
      errors++; $display("FAIL lw_10_after_err: rdata=%h err=%b, need 80adbeef/0", rd, er);
    end
    xact(1'b0, W, 32'h400, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL lw_400_range: err=%b rdata=%h, need 1/0", er, rd);
    end
    xact(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL f3_011: err=%b rdata=%h, need 1/0", er, rd);
    end
    xact(1'b1, BU, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL store_bu: err=%b, need 1", er);
    end
    xact(1'b1, W, 32'h0, 32'h11223344, rd, er, lat);
    xact(1'b1, W, 32'h400, 32'hFFFFFFFF, rd, er, lat);
    xact(1'b0, W, 32'h0, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h11223344) begin
      errors++; $display("FAIL no_wrap_0: rdata=%h, need 11223344", rd);
    end
  endtask

  task automatic test_stall;
    int lat;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = W; req_addr = 32'h10; req_wdata = 32'h0;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL stall_ready_pre: got %b, need 1", req_ready);
    end
    @(posedge clk); #1;
    req_addr = 32'h40;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== 2 || rsp_rdata !== 32'h80ADBEEF) begin
      errors++; $display("FAIL stall_first: lat=%0d rdata=%h, need 2/80adbeef", lat, rsp_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h80ADBEEF || req_ready !== 1'b0 || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d: valid=%b rdata=%h ready=%b err=%b, need 1/80adbeef/0/0",
                 i, rsp_valid, rsp_rdata, req_ready, rsp_err);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL stall_handshake: valid=%b ready=%b, need 0/1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL stall_accept: ready=%b, need 0", req_ready);
    end
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== 2 || rsp_rdata !== 32'hCAFE5A00) begin
      errors++; $display("FAIL stall_second: lat=%0d rdata=%h, need 2/cafe5a00", lat, rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, W, 32'h20, 32'hA5A5A5A5, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = W; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_outputs: valid=%b rdata=%h err=%b ready=%b, need 0/0/0/1",
               rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
    xact(1'b0, W, 32'h20, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
      errors++; $display("FAIL rst_wait_nowrite: rdata=%h err=%b, need a5a5a5a5/0", rd, er);
    end
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = W; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_resp_drop: valid=%b rdata=%h ready=%b, need 0/0/1", rsp_valid, rsp_rdata, req_ready);
    end
    xact(1'b0, W, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h80ADBEEF || lat !== 2) begin
      errors++; $display("FAIL rst_recover: rdata=%h lat=%0d, need 80adbeef/2", rd, lat);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
